mbldcm_div_arbiter: RTL and testbench
=====================================

# mbldcm_div_arbiter

Time-multiplexes one pipelined unsigned divider (`mBldcm_UDiv`) between several requesters in the BLDC motor controller, e.g. speed, period and duty-scaling computations. Each request is accepted with a one-cycle acknowledge and tagged with its requester ID and a divide-by-zero flag. The tag travels in a shift register that mirrors the divider pipeline. Results return on a shared bus with a one-hot per-requester valid strobe.

## Interface
- pNumReq, 4, number of requesters (2..16)
- pWidthDenom, 32, denominator width
- pWidthNumer, 32, numerator/quotient/remainder width
- pPipelineDepth, 7, divider pipeline depth, passed to `mBldcm_UDiv`
- iClock  in  1  sole clock
- iReset_n  in  1  reset, asynchronous assert, active-low
- iEnable  in  1  global advance; low freezes arbitration, divider and tag pipe
- iReq  in  pNumReq  per-requester request level, held until acked
- iNumer  in  pNumReq*pWidthNumer  packed numerators, requester i at slice i
- iDenom  in  pNumReq*pWidthDenom  packed denominators
- oAck  out  pNumReq  one-hot pulse: request accepted this cycle
- oResultValid  out  pNumReq  one-hot pulse: result for requester i on bus
- oQuotient  out  pWidthNumer  quotient
- oRemain  out  pWidthNumer  remainder
- oDivZero  out  1  result came from a zero denominator
- oBusy  out  1  any operation in flight

## Operation
- Arbitration is round-robin. The search starts at the requester after the last granted one. The pointer resets to pNumReq-1, so requester 0 wins first.
- At most one grant per cycle. A grant happens only when iEnable=1 and at least one iReq bit is set.
- A grant updates the pointer and pulses oAck[g] combinationally in the grant cycle.
- On the clock edge ending the grant cycle:
  - the granted operands are registered into the divider input stage;
  - the tag {valid=1, id=g, divz=(denom==0)} enters tag pipe stage 0.
- Tag pipe: pPipelineDepth+1 stages, shifts only when iEnable=1. The divider's clock enable is iEnable.
- A cycle with no grant and iEnable=1 inserts a bubble (valid=0) into the tag pipe.
- Output stage is driven by the last tag stage:
  - valid=1 gives oResultValid = one-hot(id);
  - oQuotient/oRemain come from the divider;
  - divz=1 overrides oQuotient to all-ones and oRemain to 0, and sets oDivZero=1.
- oResultValid, oDivZero: combinational from the last tag stage, gated by iEnable, so each pulse lasts exactly one enabled cycle.
- When oResultValid is 0, oQuotient, oRemain and oDivZero are 0.
- Requesters must sink results unconditionally; there is no result backpressure.
- oBusy = OR of all tag valid bits.
- A requester may hold iReq after its ack to issue back-to-back requests. It is rearbitrated fairly each cycle.
- Requesters must keep iReq and operands stable until acked. Dropping iReq before ack withdraws the request; this is legal.

## Timing
- Accept in cycle T (oAck high) gives oResultValid in cycle T+1+pPipelineDepth: 8 by default, counting enabled cycles only.
- Throughput is one division per enabled cycle. N simultaneous requests finish in N consecutive cycles, in round-robin order.
- iEnable low during cycle X:
  - no grant, no oAck, no oResultValid;
  - all pipeline and tag state holds;
  - latency stretches by the number of disabled cycles.
- Reset (asynchronous, mid-operation allowed):
  - all tag valids clear, pointer goes to pNumReq-1;
  - all outputs go to 0; in-flight results are discarded and never reported;
  - the divider is cleared through its own reset.
- First grant is possible in the first enabled cycle after reset deassertion.

## Structure
- Shared header: `MF_BLDCM_CLOG2` for the ID width (clog2 of pNumReq, minimum 1), and the tag field layout as localparam offsets (valid, id, divz).
- Sub-module `mbldcm_rr_arbiter`:
  - parameter pNumReq; ports iClock, iReset_n, iEnable, iReq → oGrant one-hot, oGrantId, oGrantValid;
  - contains the rotating pointer.
- Top level contains: `mbldcm_rr_arbiter`, the operand mux and input register, the `mBldcm_UDiv` instance, the tag shift register, and output gating.

## Test plan
- Single request: requester 2, numer 1000, denom 7, iEnable=1. Expect oAck[2] at T; oResultValid=4'b0100 at T+8 with quotient 142, remainder 6.
- Contention: all 4 requesters request at T with distinct operands. Expect oAck order 0,1,2,3 in T..T+3 and results in the same order at T+8..T+11, each with the correct quotient.
- Divide by zero: requester 1, numer 55, denom 0. Expect oResultValid[1] and oDivZero=1 with oQuotient=all-ones and oRemain=0 at T+8.
- Enable stall: iEnable low for 3 cycles at T+4 after an accept at T. Expect the result at T+11 and no pulses during the stall.
- Reset mid-flight: assert iReset_n=0 at T+3 with 3 operations in flight. Expect outputs to go to 0 immediately, no oResultValid after release, and the next grant to requester 0.
- Fairness under saturation: requesters 0 and 3 hold iReq for 20 cycles. Expect strictly alternating acks, 10 each.

Source files
------------

// File: rtl/mbldcm_div_arbiter_pkg.sv
// Shared definitions for the divider arbiter slice.
//   mf_bldcm_clog2 : ceil(log2(n)), never less than 1; sizes requester IDs.
//   TAG_*_OFS      : bit layout of the tag carried alongside the divider
//                    pipeline {id, divz, valid}. The id field starts at
//                    TAG_ID_OFS and is mf_bldcm_clog2(pNumReq) bits wide.
package mbldcm_div_arbiter_pkg;

  localparam int TAG_VLD_OFS  = 0;
  localparam int TAG_DIVZ_OFS = 1;
  localparam int TAG_ID_OFS   = 2;

  function automatic int mf_bldcm_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mBldcm_UDiv.sv
// Pipelined unsigned restoring divider.
//   iClock, iReset_n : clock, asynchronous active-low reset (clears stages)
//   iEnable          : clock enable; low holds every stage
//   iNumer, iDenom   : operands, sampled into stage 0
//   oQuotient/oRemain: result pPipelineDepth enabled cycles later
// Each stage retires ceil(W/D) quotient bits. A zero denominator yields
// an all-ones quotient and remainder = numerator (the caller overrides).
module mBldcm_UDiv #(
  parameter int pWidthNumer    = 32,
  parameter int pWidthDenom    = 32,
  parameter int pPipelineDepth = 7
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  input  logic                   iEnable,
  input  logic [pWidthNumer-1:0] iNumer,
  input  logic [pWidthDenom-1:0] iDenom,
  output logic [pWidthNumer-1:0] oQuotient,
  output logic [pWidthNumer-1:0] oRemain
);

  localparam int D   = pPipelineDepth;
  localparam int RW  = ((pWidthNumer > pWidthDenom) ? pWidthNumer : pWidthDenom) + 1;
  localparam int BPS = (pWidthNumer + D - 1) / D;
  localparam int DN  = (D > 1) ? D - 1 : 1;

  logic [RW-1:0]          rem_in [D];
  logic [pWidthNumer-1:0] quo_in [D];
  logic [pWidthDenom-1:0] den_in [D];
  logic [RW-1:0]          rem_d  [D];
  logic [pWidthNumer-1:0] quo_d  [D];
  logic [RW-1:0]          rem_q  [D];
  logic [pWidthNumer-1:0] quo_q  [D];
  logic [pWidthDenom-1:0] den_q  [DN];

  always_comb begin
    rem_in[0] = '0;
    quo_in[0] = iNumer;
    den_in[0] = iDenom;
    for (int k = 1; k < D; k++) begin
      rem_in[k] = rem_q[k-1];
      quo_in[k] = quo_q[k-1];
      den_in[k] = den_q[k-1];
    end
    // quo doubles as the numerator shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    for (int k = 0; k < D; k++) begin
      rem_d[k] = rem_in[k];
      quo_d[k] = quo_in[k];
      for (int s = 0; s < BPS; s++) begin
        if (k * BPS + s < pWidthNumer) begin
          rem_d[k] = {rem_d[k][RW-2:0], quo_d[k][pWidthNumer-1]};
          quo_d[k] = {quo_d[k][pWidthNumer-2:0], 1'b0};
          if (rem_d[k] >= RW'(den_in[k])) begin
            rem_d[k]    = rem_d[k] - RW'(den_in[k]);
            quo_d[k][0] = 1'b1;
          end
        end
      end
    end
  end

  // Stage boundary: one register set per pipeline stage
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int k = 0; k < D; k++) begin
        rem_q[k] <= '0;
        quo_q[k] <= '0;
      end
      for (int k = 0; k < DN; k++) den_q[k] <= '0;
    end else if (iEnable) begin
      for (int k = 0; k < D; k++) begin
        rem_q[k] <= rem_d[k];
        quo_q[k] <= quo_d[k];
      end
      for (int k = 0; k < DN; k++) den_q[k] <= den_in[k];
    end
  end

  assign oQuotient = quo_q[D-1];
  assign oRemain   = rem_q[D-1][pWidthNumer-1:0];

endmodule

// File: rtl/mbldcm_rr_arbiter.sv
// Round-robin arbiter with a rotating pointer.
//   iClock, iReset_n : clock, asynchronous active-low reset
//   iEnable          : grants only happen in enabled cycles
//   iReq             : per-requester request levels
//   oGrant           : one-hot grant (combinational, this cycle)
//   oGrantId         : index of the granted requester
//   oGrantValid      : a grant is issued this cycle
// The pointer holds the last granted ID; the search starts one above it.
// Reset value pNumReq-1 makes requester 0 the first winner.
module mbldcm_rr_arbiter
  import mbldcm_div_arbiter_pkg::*;
#(
  parameter int pNumReq = 4
) (
  input  logic                                iClock,
  input  logic                                iReset_n,
  input  logic                                iEnable,
  input  logic [pNumReq-1:0]                  iReq,
  output logic [pNumReq-1:0]                  oGrant,
  output logic [mf_bldcm_clog2(pNumReq)-1:0]  oGrantId,
  output logic                                oGrantValid
);

  localparam int IDW = mf_bldcm_clog2(pNumReq);

  logic [IDW-1:0]     ptr_d, ptr_q;
  logic [pNumReq-1:0] upper_req;
  logic [IDW-1:0]     upper_id, lower_id;

  // Requests strictly above the pointer take priority; otherwise wrap
  // around to the lowest requesting index.
  always_comb begin
    upper_req = '0;
    upper_id  = '0;
    lower_id  = '0;
    for (int j = pNumReq - 1; j >= 0; j--) begin
      upper_req[j] = iReq[j] && (j > int'(ptr_q));
      if (iReq[j]) lower_id = IDW'(j);
    end
    for (int j = pNumReq - 1; j >= 0; j--) begin
      if (upper_req[j]) upper_id = IDW'(j);
    end
    // Reset gating keeps oAck quiet while the block is held in reset.
    oGrantValid = iReset_n && iEnable && (|iReq);
    oGrantId    = (|upper_req) ? upper_id : lower_id;
    oGrant      = '0;
    if (oGrantValid) oGrant[oGrantId] = 1'b1;
    ptr_d = oGrantValid ? oGrantId : ptr_q;
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) ptr_q <= IDW'(pNumReq - 1);
    else           ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mbldcm_div_arbiter.sv
// Shares one pipelined divider between pNumReq requesters.
//   iClock, iReset_n : clock, asynchronous active-low reset
//   iEnable          : global advance for arbitration, divider and tag pipe
//   iReq             : request levels, held with operands until acked
//   iNumer, iDenom   : packed operands, requester i at slice i
//   oAck             : one-hot accept pulse (combinational)
//   oResultValid     : one-hot result strobe for the owning requester
//   oQuotient/oRemain: result bus, zero when no strobe
//   oDivZero         : result came from a zero denominator
//   oBusy            : any operation still in flight
// A tag {id, divz, valid} rides a shift register parallel to the divider so
// the result leaving the last stage knows whom it belongs to.
module mbldcm_div_arbiter
  import mbldcm_div_arbiter_pkg::*;
#(
  parameter int pNumReq        = 4,
  parameter int pWidthDenom    = 32,
  parameter int pWidthNumer    = 32,
  parameter int pPipelineDepth = 7
) (
  input  logic                           iClock,
  input  logic                           iReset_n,
  input  logic                           iEnable,
  input  logic [pNumReq-1:0]             iReq,
  input  logic [pNumReq*pWidthNumer-1:0] iNumer,
  input  logic [pNumReq*pWidthDenom-1:0] iDenom,
  output logic [pNumReq-1:0]             oAck,
  output logic [pNumReq-1:0]             oResultValid,
  output logic [pWidthNumer-1:0]         oQuotient,
  output logic [pWidthNumer-1:0]         oRemain,
  output logic                           oDivZero,
  output logic                           oBusy
);

  localparam int IDW   = mf_bldcm_clog2(pNumReq);
  localparam int TAG_W = TAG_ID_OFS + IDW;
  localparam int D     = pPipelineDepth;

  logic [pNumReq-1:0]     grant;
  logic [IDW-1:0]         grant_id;
  logic                   grant_vld;
  logic [pWidthNumer-1:0] numer_sel;
  logic [pWidthDenom-1:0] denom_sel;
  logic [pWidthNumer-1:0] numer_p0_d, numer_p0_q;
  logic [pWidthDenom-1:0] denom_p0_d, denom_p0_q;
  logic [TAG_W-1:0]       tag_d [D+1];
  logic [TAG_W-1:0]       tag_q [D+1];
  logic [pWidthNumer-1:0] div_quot, div_rem;
  logic [TAG_W-1:0]       last_tag;
  logic [IDW-1:0]         last_id;
  logic                   vld_out, divz_out, busy;

  function automatic logic [pWidthNumer-1:0] divz_quot(input logic divz,
                                                        input logic [pWidthNumer-1:0] q);
    return divz ? '1 : q;
  endfunction

  function automatic logic [pWidthNumer-1:0] divz_rem(input logic divz,
                                                       input logic [pWidthNumer-1:0] r);
    return divz ? '0 : r;
  endfunction

  mbldcm_rr_arbiter #(
    .pNumReq (pNumReq)
  ) u_arb (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iEnable     (iEnable),
    .iReq        (iReq),
    .oGrant      (grant),
    .oGrantId    (grant_id),
    .oGrantValid (grant_vld)
  );

  assign oAck      = grant;
  assign numer_sel = iNumer[int'(grant_id)*pWidthNumer +: pWidthNumer];
  assign denom_sel = iDenom[int'(grant_id)*pWidthDenom +: pWidthDenom];

  always_comb begin
    numer_p0_d = numer_p0_q;
    denom_p0_d = denom_p0_q;
    if (grant_vld) begin
      numer_p0_d = numer_sel;
      denom_p0_d = denom_sel;
    end
    // A non-granting enabled cycle pushes a bubble (all-zero tag).
    tag_d[0]                    = '0;
    tag_d[0][TAG_VLD_OFS]       = grant_vld;
    tag_d[0][TAG_DIVZ_OFS]      = grant_vld && (denom_sel == '0);
    tag_d[0][TAG_ID_OFS +: IDW] = grant_id;
    for (int k = 1; k <= D; k++) tag_d[k] = tag_q[k-1];
  end

  // Stage p0: operand register feeding the divider
  always_ff @(posedge iClock) begin
    numer_p0_q <= numer_p0_d;
    denom_p0_q <= denom_p0_d;
  end

  // Tag pipe: stage k lines up with divider stage k-1
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int k = 0; k <= D; k++) tag_q[k] <= '0;
    end else if (iEnable) begin
      for (int k = 0; k <= D; k++) tag_q[k] <= tag_d[k];
    end
  end

  mBldcm_UDiv #(
    .pWidthNumer    (pWidthNumer),
    .pWidthDenom    (pWidthDenom),
    .pPipelineDepth (pPipelineDepth)
  ) u_div (
    .iClock    (iClock),
    .iReset_n  (iReset_n),
    .iEnable   (iEnable),
    .iNumer    (numer_p0_q),
    .iDenom    (denom_p0_q),
    .oQuotient (div_quot),
    .oRemain   (div_rem)
  );

  // Output stage: strobes last exactly one enabled cycle
  assign last_tag = tag_q[D];
  assign last_id  = last_tag[TAG_ID_OFS +: IDW];
  assign vld_out  = iEnable && last_tag[TAG_VLD_OFS];
  assign divz_out = last_tag[TAG_DIVZ_OFS];

  always_comb begin
    oResultValid = '0;
    oQuotient    = '0;
    oRemain      = '0;
    oDivZero     = 1'b0;
    if (vld_out) begin
      oResultValid[last_id] = 1'b1;
      oQuotient             = divz_quot(divz_out, div_quot);
      oRemain               = divz_rem(divz_out, div_rem);
      oDivZero              = divz_out;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= D; k++) busy = busy | tag_q[k][TAG_VLD_OFS];
  end
  assign oBusy = busy;

endmodule

// File: tb/tb_mbldcm_div_arbiter.sv
module tb_mbldcm_div_arbiter;

  localparam int LAT = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [3:0]   req;
  logic [127:0] numer;
  logic [127:0] denom;
  logic [3:0]   ack;
  logic [3:0]   res_vld;
  logic [31:0]  quot;
  logic [31:0]  rem;
  logic         divz;
  logic         busy;

  mbldcm_div_arbiter #(
    .pNumReq        (4),
    .pWidthDenom    (32),
    .pWidthNumer    (32),
    .pPipelineDepth (7)
  ) dut (
    .iClock       (clk),
    .iReset_n     (rst_n),
    .iEnable      (en),
    .iReq         (req),
    .iNumer       (numer),
    .iDenom       (denom),
    .oAck         (ack),
    .oResultValid (res_vld),
    .oQuotient    (quot),
    .oRemain      (rem),
    .oDivZero     (divz),
    .oBusy        (busy)
  );

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          ack_log[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          extra_lat = 0;
  logic [31:0] num_tab[4];
  logic [31:0] den_tab[4];
  logic [31:0] q_tab[4];
  logic [31:0] r_tab[4];
  logic        dz_tab[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: every result strobe pops one expectation.
  always @(negedge clk) begin
    if (res_vld != 4'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result valid=%b q=%0h (cycle %0d)", res_vld, quot, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("res_valid", 32'(res_vld), 32'(1) << mon_e.id);
        chk("res_quot", quot, mon_e.q);
        chk("res_rem", rem, mon_e.r);
        chk("res_divz", 32'(divz), 32'(mon_e.dz));
        chk("res_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      chk("idle_bus", quot | rem | 32'(divz), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] q, input logic [31:0] r, input logic dz);
    num_tab[id] = n;
    den_tab[id] = d;
    q_tab[id]   = q;
    r_tab[id]   = r;
    dz_tab[id]  = dz;
    numer[id*32 +: 32] = n;
    denom[id*32 +: 32] = d;
  endtask

  // Raise the requests in mask and collect n_acks acceptances. Unless hold
  // is set, a requester drops its request right after its accept edge.
  task automatic serve(input logic [3:0] mask, input int n_acks, input bit do_push, input bit hold);
    int got;
    int budget;
    got = 0;
    budget = 0;
    ack_log.delete();
    req = mask;
    while (got < n_acks && budget < 64) begin
      int id;
      @(negedge clk);
      id = -1;
      for (int i = 0; i < 4; i++) if (ack[i]) id = i;
      if (id >= 0) begin
        chk("ack_onehot", 32'($onehot(ack)), 32'd1);
        ack_log.push_back(id);
        got++;
        if (do_push)
          sb.push_back('{id, q_tab[id], r_tab[id], dz_tab[id], cyc + LAT + extra_lat});
      end
      tick();
      if (id >= 0 && !hold) req[id] = 1'b0;
      budget++;
    end
    if (got < n_acks) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout got=%0d exp=%0d", got, n_acks);
    end
    req = 4'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 60) begin
      tick();
      b++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n3;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'hF;
    numer = '0;
    denom = '0;
    #2;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_valid", 32'(res_vld), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_quot", quot | rem | 32'(divz), 32'h0);
    repeat (3) tick();
    req   = 4'b0;
    rst_n = 1'b1;

    // Single request: 1000 / 7 = 142 r 6
    set_op(2, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
    serve(4'b0100, 1, 1'b1, 1'b0);
    chk("single_ack", 32'(ack_log[0]), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    drain();

    // Divide by zero
    set_op(1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    serve(4'b0010, 1, 1'b1, 1'b0);
    chk("divz_ack", 32'(ack_log[0]), 32'd1);
    drain();

    // Width extremes; pointer sits at 1, so 3 wins before 0
    set_op(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    serve(4'b1001, 2, 1'b1, 1'b0);
    chk("edge_ack0", 32'(ack_log[0]), 32'd3);
    chk("edge_ack1", 32'(ack_log[1]), 32'd0);
    drain();

    // Enable stall: 3 disabled cycles starting at T+4 push the result to T+11
    set_op(2, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
    extra_lat = 3;
    serve(4'b0100, 1, 1'b1, 1'b0);
    extra_lat = 0;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    en = 1'b1;
    drain();

    // Fairness: requesters 0 and 3 saturate for 20 cycles
    set_op(0, 32'd20, 32'd4, 32'd5, 32'd0, 1'b0);
    set_op(3, 32'd21, 32'd4, 32'd5, 32'd1, 1'b0);
    serve(4'b1001, 20, 1'b1, 1'b1);
    n0 = 0;
    n3 = 0;
    foreach (ack_log[i]) begin
      if (ack_log[i] == 0) n0++;
      if (ack_log[i] == 3) n3++;
      if (i > 0) chk("fair_alternate", 32'(ack_log[i] != ack_log[i-1]), 32'd1);
    end
    chk("fair_first", 32'(ack_log[0]), 32'd3);
    chk("fair_cnt0", 32'(n0), 32'd10);
    chk("fair_cnt3", 32'(n3), 32'd10);
    drain();

    // Reset with three operations in flight: nothing may come back
    set_op(0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    set_op(1, 32'd8, 32'd3, 32'd2, 32'd2, 1'b0);
    set_op(2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    serve(4'b0111, 3, 1'b0, 1'b0);
    chk("inflight_busy", 32'(busy), 32'd1);
    req   = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(ack), 32'h0);
    chk("midrst_valid", 32'(res_vld), 32'h0);
    req = 4'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("postrst_busy", 32'(busy), 32'd0);

    // Contention after reset: round-robin order 0,1,2,3, results in order
    set_op(0, 32'd100, 32'd3, 32'd33, 32'd1, 1'b0);
    set_op(1, 32'd65535, 32'd256, 32'd255, 32'd255, 1'b0);
    set_op(2, 32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0);
    set_op(3, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0);
    serve(4'b1111, 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("contend_order", 32'(ack_log[i]), 32'(i));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
